// File: rtl/spi_voice_regfile.sv
// spi_voice_regfile: SPI-side command decoder and per-voice divider register bank.
// Optional read-back path is built when VOICE_REGFILE_READBACK_EN is defined.
module spi_voice_regfile #(
  parameter int unsigned N_VOICES  = 8,
  parameter int unsigned D_W       = 16,
  parameter int unsigned RESET_DIV = 1024
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic                      frame_active,
  input  logic [7:0]                rx_byte,
  input  logic                      rx_valid,
  output logic [7:0]                tx_byte,
  output logic [N_VOICES*D_W-1:0]   voice_div,
  output logic [N_VOICES-1:0]       div_update,
  output logic                      cmd_err
);

  localparam int unsigned W_BYTES = D_W / 8;
  localparam int unsigned IDX_W   = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
  localparam int unsigned CNT_W   = (W_BYTES > 1) ? $clog2(W_BYTES) : 1;
  localparam logic [D_W-1:0] RST_WORD = D_W'(RESET_DIV);
  localparam logic [7:0] TX_ACK  = 8'hFF;
  localparam logic [7:0] TX_OK   = 8'h01;
  localparam logic [7:0] TX_NULL = 8'h00;

  typedef enum logic [2:0] {IDLE, WR_DATA, RD_TURN, RD_DATA, DRAIN} state_t;

  state_t                    state_q, state_n;
  logic [IDX_W-1:0]          idx_q, idx_n, idx_inc;
  logic [CNT_W-1:0]          cnt_q, cnt_n;
  logic                      ai_q, ai_n;
  logic [D_W-1:0]            shadow_q, shadow_n, wr_word;
  logic [7:0]                tx_n;
  logic [N_VOICES*D_W-1:0]   voice_n;
  logic [N_VOICES-1:0]       upd_n;
  logic                      err_n;
  logic                      cmd_valid;
  logic                      cnt_last;

  // Command decode helpers and the write-side byte accumulator
  assign cmd_valid = {1'b0, rx_byte[5:0]} < 7'(N_VOICES);
  assign idx_inc   = (N_VOICES == 1) ? '0 : idx_q + IDX_W'(1);
  assign cnt_last  = (cnt_q == CNT_W'(W_BYTES - 1));
  assign wr_word   = (shadow_q << 8) | D_W'(rx_byte);

`ifdef VOICE_REGFILE_READBACK_EN
  logic [D_W-1:0] cur_word, next_word, rd_shift;

  // Read-side words: current voice, next voice for auto-increment, shifted shadow
  assign cur_word  = voice_div[idx_q*D_W +: D_W];
  assign next_word = voice_div[idx_inc*D_W +: D_W];
  assign rd_shift  = shadow_q << 8;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_n  = state_q;
    idx_n    = idx_q;
    cnt_n    = cnt_q;
    ai_n     = ai_q;
    shadow_n = shadow_q;
    tx_n     = tx_byte;
    voice_n  = voice_div;
    upd_n    = '0;
    err_n    = 1'b0;
    if (!frame_active) begin
      state_n  = IDLE;
      cnt_n    = '0;
      shadow_n = '0;
      tx_n     = TX_ACK;
    end else if (rx_valid) begin
      case (state_q)
        IDLE: begin
          idx_n    = IDX_W'(rx_byte[5:0]);
          ai_n     = rx_byte[6];
          cnt_n    = '0;
          shadow_n = '0;
          if (!cmd_valid) begin
            state_n = DRAIN;
            tx_n    = TX_NULL;
            err_n   = 1'b1;
          end else if (rx_byte[7]) begin
            state_n = WR_DATA;
            tx_n    = TX_OK;
          end else begin
`ifdef VOICE_REGFILE_READBACK_EN
            state_n = RD_TURN;
            tx_n    = TX_OK;
`else
            state_n = DRAIN;
            tx_n    = TX_NULL;
`endif
          end
        end
        WR_DATA: begin
          tx_n = TX_NULL;
          if (cnt_last) begin
            voice_n[idx_q*D_W +: D_W] = wr_word;
            upd_n[idx_q]              = 1'b1;
            shadow_n                  = '0;
            cnt_n                     = '0;
            if (ai_q) idx_n = idx_inc;
            else      state_n = DRAIN;
          end else begin
            shadow_n = wr_word;
            cnt_n    = cnt_q + CNT_W'(1);
          end
        end
`ifdef VOICE_REGFILE_READBACK_EN
        RD_TURN: begin
          shadow_n = cur_word;
          tx_n     = cur_word[D_W-1 -: 8];
          cnt_n    = '0;
          state_n  = RD_DATA;
        end
        RD_DATA: begin
          if (!cnt_last) begin
            shadow_n = rd_shift;
            tx_n     = rd_shift[D_W-1 -: 8];
            cnt_n    = cnt_q + CNT_W'(1);
          end else if (ai_q) begin
            idx_n    = idx_inc;
            shadow_n = next_word;
            tx_n     = next_word[D_W-1 -: 8];
            cnt_n    = '0;
          end else begin
            tx_n    = TX_NULL;
            state_n = DRAIN;
          end
        end
`endif
        DRAIN: begin
          tx_n = TX_NULL;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      ai_q       <= 1'b0;
      shadow_q   <= '0;
      tx_byte    <= TX_ACK;
      voice_div  <= {N_VOICES{RST_WORD}};
      div_update <= '0;
      cmd_err    <= 1'b0;
    end else begin
      state_q    <= state_n;
      idx_q      <= idx_n;
      cnt_q      <= cnt_n;
      ai_q       <= ai_n;
      shadow_q   <= shadow_n;
      tx_byte    <= tx_n;
      voice_div  <= voice_n;
      div_update <= upd_n;
      cmd_err    <= err_n;
    end
  end

endmodule
